// File: rtl/fft_ctrl_seq.sv
// Run-time sized radix-2 DIT FFT sequencer over ping-pong RAM banks with a delayed butterfly write-back.
// Optional FFT_PERF_CNT_EN adds the cycle_cnt compute/drain performance counter.
module fft_ctrl_seq #(
    parameter int M_MAX    = 9,
    parameter int BFLY_LAT = 3,
    parameter int CNT_W    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         log2n,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [M_MAX-1:0]   out_idx,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_sel,
    output logic               we0,
    output logic               we1,
    output logic [M_MAX-1:0]   adr0_a,
    output logic [M_MAX-1:0]   adr0_b,
    output logic [M_MAX-1:0]   adr1_a,
    output logic [M_MAX-1:0]   adr1_b,
    output logic [M_MAX-2:0]   twiddle_adr
`ifdef FFT_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt
`endif
);

    localparam int DW = $clog2(BFLY_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         n_q, n_d;
    logic [3:0]         s_q, s_d;
    logic [M_MAX-1:0]   load_cnt_q, load_cnt_d;
    logic [M_MAX-2:0]   b_q, b_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [M_MAX-1:0]   idx_q, idx_d;

    logic               wr_vld_q   [BFLY_LAT];
    logic [M_MAX-1:0]   wr_adr_a_q [BFLY_LAT];
    logic [M_MAX-1:0]   wr_adr_b_q [BFLY_LAT];

    logic               issue;
    logic               legal_n;
    logic               start_ok;
    logic [M_MAX-1:0]   n_mask;
    logic [M_MAX-2:0]   half_mask;
    logic [M_MAX-1:0]   rd_adr_a;
    logic [M_MAX-1:0]   rd_adr_b;
    logic [M_MAX-2:0]   tw_adr;

    // Reverse the low n bits of x; bits at n and above come out as zero.
    function automatic logic [M_MAX-1:0] bitrev_n(input logic [M_MAX-1:0] x, input logic [3:0] n);
        logic [M_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < M_MAX; i++) begin
            r[i] = x[M_MAX-1-i];
        end
        return r >> (4'(M_MAX) - n);
    endfunction

    // Spread butterfly index b around a zero at bit s to form the upper-leg address.
    function automatic logic [M_MAX-1:0] ins_zero(input logic [M_MAX-2:0] b, input logic [3:0] s);
        logic [M_MAX-1:0] bw;
        logic [M_MAX-1:0] lo_mask;
        bw      = {1'b0, b};
        lo_mask = ~({M_MAX{1'b1}} << s);
        return ((bw & ~lo_mask) << 1) | (bw & lo_mask);
    endfunction

    function automatic logic [M_MAX-2:0] twiddle_of(input logic [M_MAX-2:0] b, input logic [3:0] s);
        logic [M_MAX-2:0] tw_mask;
        tw_mask = ~({(M_MAX-1){1'b1}} << s);
        return (b & tw_mask) << (4'(M_MAX - 1) - s);
    endfunction

    assign legal_n   = (log2n >= 4'd4) && (int'(log2n) <= M_MAX);
    assign start_ok  = (state_q == S_IDLE) && start && legal_n;
    assign n_mask    = ~({M_MAX{1'b1}} << n_q);
    assign half_mask = n_mask[M_MAX-1:1];
    assign rd_adr_a  = ins_zero(b_q, s_q);
    assign rd_adr_b  = rd_adr_a | (M_MAX'(1) << s_q);
    assign tw_adr    = twiddle_of(b_q, s_q);
    assign busy      = (state_q != S_IDLE);
    assign out_idx   = idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            s_q        <= '0;
            load_cnt_q <= '0;
            b_q        <= '0;
            drain_q    <= '0;
            idx_q      <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                wr_vld_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            s_q        <= s_d;
            load_cnt_q <= load_cnt_d;
            b_q        <= b_d;
            drain_q    <= drain_d;
            idx_q      <= idx_d;
            wr_vld_q[0] <= issue;
            for (int i = 1; i < BFLY_LAT; i++) begin
                wr_vld_q[i] <= wr_vld_q[i-1];
            end
        end
    end

    // Write-back address pipeline; only qualified by wr_vld_q, so no reset needed.
    always_ff @(posedge clk) begin
        wr_adr_a_q[0] <= rd_adr_a;
        wr_adr_b_q[0] <= rd_adr_b;
        for (int i = 1; i < BFLY_LAT; i++) begin
            wr_adr_a_q[i] <= wr_adr_a_q[i-1];
            wr_adr_b_q[i] <= wr_adr_b_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        s_d         = s_q;
        load_cnt_d  = load_cnt_q;
        b_d         = b_q;
        drain_d     = drain_q;
        idx_d       = idx_q;
        issue       = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rd_sel      = 1'b0;
        we0         = 1'b0;
        we1         = 1'b0;
        adr0_a      = '0;
        adr0_b      = '0;
        adr1_a      = '0;
        adr1_b      = '0;
        twiddle_adr = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal_n) begin
                        n_d        = log2n;
                        load_cnt_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we0    = 1'b1;
                    adr0_a = bitrev_n(load_cnt_q, n_q);
                    adr0_b = bitrev_n(load_cnt_q, n_q);
                    if (load_cnt_q == n_mask) begin
                        load_cnt_d = '0;
                        s_d        = '0;
                        b_d        = '0;
                        state_d    = S_COMPUTE;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                issue       = 1'b1;
                rd_sel      = s_q[0];
                twiddle_adr = tw_adr;
                if (s_q[0]) begin
                    adr1_a = rd_adr_a;
                    adr1_b = rd_adr_b;
                end else begin
                    adr0_a = rd_adr_a;
                    adr0_b = rd_adr_b;
                end
                if (b_q == half_mask) begin
                    b_d     = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            S_DRAIN: begin
                rd_sel = s_q[0];
                if (drain_q == DW'(BFLY_LAT - 1)) begin
                    if (s_q < n_q - 4'd1) begin
                        s_d     = s_q + 4'd1;
                        state_d = S_COMPUTE;
                    end else begin
                        s_d     = '0;
                        idx_d   = '0;
                        state_d = S_UNLOAD;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                rd_sel    = n_q[0];
                if (n_q[0]) begin
                    adr1_a = idx_q;
                end else begin
                    adr0_a = idx_q;
                end
                if (out_ready) begin
                    if (idx_q == n_mask) begin
                        done    = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Write bank is the opposite of the read bank for the current stage.
        if ((state_q == S_COMPUTE || state_q == S_DRAIN) && wr_vld_q[BFLY_LAT-1]) begin
            if (s_q[0]) begin
                we0    = 1'b1;
                adr0_a = wr_adr_a_q[BFLY_LAT-1];
                adr0_b = wr_adr_b_q[BFLY_LAT-1];
            end else begin
                we1    = 1'b1;
                adr1_a = wr_adr_a_q[BFLY_LAT-1];
                adr1_b = wr_adr_b_q[BFLY_LAT-1];
            end
        end

        if (reset) begin
            we0 = 1'b0;
            we1 = 1'b0;
        end
    end

`ifdef FFT_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (start_ok) begin
            cyc_q <= '0;
        end else if ((state_q == S_COMPUTE || state_q == S_DRAIN) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycle_cnt = cyc_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: doc/fft_ctrl_seq.md
Name: fft_ctrl_seq

Overview:
Parametrised successor to the single-size FFT controller. It sequences a radix-2 decimation-in-time FFT over two ping-pong RAM banks (RAM0/RAM1) and a twiddle ROM. The FFT size is selectable at run time, from 16 points up to 2^M_MAX points. Sample loading uses a valid/ready handshake with bit-reversed addressing, and results are unloaded through a valid/ready handshake. Butterfly write-back is delayed to match a pipelined butterfly datapath.

Parameters:
M_MAX, 9, log2 of the maximum FFT size; sets address width.
BFLY_LAT, 3, butterfly read-to-write latency in cycles (>=1).
CNT_W, 20, width of the optional performance counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; accepted only in IDLE
log2n  in  4  FFT size select, latched on an accepted start; legal range 4..M_MAX
in_valid  in  1  load sample valid
in_ready  out  1  high in LOAD
out_valid  out  1  high in UNLOAD
out_ready  in  1  consumer accepts the unload beat
out_idx  out  M_MAX  natural-order index of the current unload beat
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the final unload beat
err  out  1  one-cycle pulse when start is given with an illegal log2n
rd_sel  out  1  bank holding the butterfly read source (0=RAM0); during UNLOAD, the result bank
we0, we1  out  1  bank write enables
adr0_a, adr0_b, adr1_a, adr1_b  out  M_MAX  bank addresses
twiddle_adr  out  M_MAX-1  twiddle ROM address
cycle_cnt  out  CNT_W  present only under FFT_PERF_CNT_EN

Behaviour:
- Reset values: state IDLE; all outputs 0; all counters 0. Reset has priority over every other input, including mid-LOAD, COMPUTE or UNLOAD; the FSM returns to IDLE the next cycle and all write enables drop immediately.
- Notation: n = latched log2n, N = 2^n.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
- IDLE:
  - start with 4<=log2n<=M_MAX: latch n, go to LOAD.
  - start with an illegal log2n: pulse err, stay in IDLE.
- LOAD:
  - Each in_valid beat writes RAM0: we0=1, adr0_a=adr0_b=bitrev_n(load_cnt). bitrev_n reverses the low n bits; upper bits are 0.
  - load_cnt increments per beat. After beat N-1, go to COMPUTE with stage s=0 and butterfly b=0.
  - in_valid low inserts a bubble; no write occurs.
- COMPUTE, one butterfly per cycle, N/2 per stage:
  - adr_a = b with a 0 inserted at bit s; adr_b = adr_a | (1<<s).
  - twiddle_adr = (b mod 2^s) << (M_MAX-1-s).
  - Read bank = RAM0 when s is even, RAM1 when s is odd; rd_sel = s[0].
  - The read bank's a/b ports carry adr_a/adr_b.
  - The write bank's a/b ports carry adr_a/adr_b delayed BFLY_LAT cycles, and its write enable is the issue-valid signal delayed BFLY_LAT cycles.
  - After b = N/2-1, go to DRAIN.
- DRAIN:
  - Wait BFLY_LAT cycles until the write pipeline is empty. No new reads are issued.
  - If s<n-1: s++, b=0, return to COMPUTE.
  - Otherwise go to UNLOAD.
  - This prevents a read-after-write hazard across stages.
- UNLOAD:
  - Result bank = RAM1 if n is odd, RAM0 if n is even; rd_sel reflects it.
  - out_idx drives port a of the result bank. Data is valid on the RAM read port one cycle after each out_valid & out_ready beat.
  - out_idx advances per accepted beat.
  - The beat with out_idx=N-1 pulses done; the FSM then goes to IDLE.
- Port muxing:
  - Unused address ports hold 0.
  - we0 and we1 are never both high.
  - start outside IDLE is ignored.
- Total cycles with no stalls: N load + n*(N/2+BFLY_LAT) compute + N unload.

Optional Feature:
FFT_PERF_CNT_EN:
- Defined: cycle_cnt clears on an accepted start, increments each cycle in COMPUTE or DRAIN, and saturates at all-ones. It holds its value until the next start.
- Undefined: the cycle_cnt port and its logic are absent.

Test Plan:
- reset, then start with log2n=4, stream 16 samples without stalls -> writes at RAM0 addresses 0,8,4,12,2,...,15; 4 stages of 8 butterflies each; UNLOAD from RAM0; done on beat 15.
- log2n=5 with BFLY_LAT=3 -> stage-0 write-bank pairs (0,1),(2,3),...; we1 lags reads by exactly 3 cycles; UNLOAD from RAM1; rd_sel=1.
- log2n=9, stage s=8, b=5 -> adr_a=5, adr_b=261, twiddle_adr=5.
- start with log2n=3, then log2n=10 (M_MAX=9) -> err pulses each time; busy stays 0.
- in_valid toggled every other cycle and out_ready low for 3 cycles mid-unload -> no extra writes; out_idx holds; done still fires exactly once.
- reset asserted in COMPUTE stage 2 -> next cycle IDLE, we0=we1=0, busy=0; a new start then runs a normal FFT.
